pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline register that replaces the fixed per-stage latch registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries an opaque control field and data field between stages under a valid/ready handshake. It has an optional two-entry skid buffer so back-pressure need not be combinational across stages. It supports synchronous flush, and it zeroes control bits whenever the output is empty, so a downstream stage never sees a stale register- or memory-write enable.

---
 rtl/pipe_stage_reg.sv | 123 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic elastic pipeline register: valid/ready handshake, optional two-entry skid,
// synchronous flush, and control bits masked to zero whenever the stage is empty.
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 96,
    parameter int SKID   = 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [CTRL_W-1:0] IN_CTRL,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [CTRL_W-1:0] OUT_CTRL,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [1:0]        COUNT
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CTRL_W-1:0]  main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]  main_data_q, main_data_d;
    logic [CTRL_W-1:0]  skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]  skid_data_q, skid_data_d;
    logic               out_valid_q;
    logic               in_ready_q;
    logic               in_ready_s;
    logic               in_hs_s;
    logic               out_hs_s;

    // With a skid entry, ready comes straight from a flop so back-pressure never ripples upstream.
    assign in_ready_s = (SKID != 0) ? in_ready_q : (!out_valid_q || OUT_READY);
    assign in_hs_s    = IN_VALID && in_ready_s;
    assign out_hs_s   = out_valid_q && OUT_READY;

    assign IN_READY  = in_ready_s;
    assign OUT_VALID = out_valid_q;
    assign OUT_CTRL  = main_ctrl_q & {CTRL_W{out_valid_q}};
    assign OUT_DATA  = main_data_q;
    assign COUNT     = state_q;

    // Next-state and storage-load decisions for the handshake state machine.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (FLUSH) begin
            // Flush drops anything arriving this cycle; held payloads are left in place.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_hs_s) begin
                        main_ctrl_d = IN_CTRL;
                        main_data_d = IN_DATA;
                        state_d     = ST_BUSY;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (in_hs_s && out_hs_s) begin
                        main_ctrl_d = IN_CTRL;
                        main_data_d = IN_DATA;
                        state_d     = ST_BUSY;
                    end else if (in_hs_s && (SKID != 0)) begin
                        skid_ctrl_d = IN_CTRL;
                        skid_data_d = IN_DATA;
                        state_d     = ST_FULL;
                    end else if (out_hs_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
                ST_FULL: begin
                    if (out_hs_s) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        state_d     = ST_BUSY;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State, storage and registered handshake flags.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= {CTRL_W{1'b0}};
            main_data_q <= {DATA_W{1'b0}};
            skid_ctrl_q <= {CTRL_W{1'b0}};
            skid_data_q <= {DATA_W{1'b0}};
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            out_valid_q <= (state_d != ST_EMPTY);
            in_ready_q  <= (state_d != ST_FULL);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=0 and one SKID=1 instance, each checked every cycle
// against a queue model, plus directed literal checks for reset, streaming, skid, flush.
module tb_pipe_stage_reg;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst_n, flush;
    logic        ivld [2];
    logic        ordy [2];
    logic [7:0]  ictl [2];
    logic [95:0] idat [2];
    logic        ir   [2];
    logic        ov   [2];
    logic [7:0]  octl [2];
    logic [95:0] odat [2];
    logic [1:0]  cnt  [2];

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(96), .SKID(0)) u_skid0 (
        .CLK(CLK), .RESET_N(rst_n), .FLUSH(flush),
        .IN_VALID(ivld[0]), .IN_READY(ir[0]), .IN_CTRL(ictl[0]), .IN_DATA(idat[0]),
        .OUT_VALID(ov[0]), .OUT_READY(ordy[0]), .OUT_CTRL(octl[0]), .OUT_DATA(odat[0]),
        .COUNT(cnt[0])
    );

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(96), .SKID(1)) u_skid1 (
        .CLK(CLK), .RESET_N(rst_n), .FLUSH(flush),
        .IN_VALID(ivld[1]), .IN_READY(ir[1]), .IN_CTRL(ictl[1]), .IN_DATA(idat[1]),
        .OUT_VALID(ov[1]), .OUT_READY(ordy[1]), .OUT_CTRL(octl[1]), .OUT_DATA(odat[1]),
        .COUNT(cnt[1])
    );

    // Model: each stage is a FIFO of {ctrl,data}; capacity 2 with skid, else 1 with pass-through ready.
    typedef logic [103:0] ent_t;
    ent_t        mq [2][$];
    logic [95:0] last [2];
    int          vectors = 0;
    int          miscompares = 0;
    bit          chk_en = 1'b0;

    task automatic chk(input string nm, input logic [103:0] act, input logic [103:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic exp_ready(input int k);
        int n;
        n = mq[k].size();
        if (k == 1) return (n < 2);
        return (n == 0) || ordy[k];
    endfunction

    always @(posedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            logic acc;
            acc = ivld[k] && exp_ready(k);
            if (!rst_n) begin
                mq[k].delete();
                last[k] = 96'd0;
            end else begin
                if (mq[k].size() > 0 && ordy[k]) void'(mq[k].pop_front());
                if (flush) mq[k].delete();
                else if (acc) mq[k].push_back({ictl[k], idat[k]});
                if (mq[k].size() > 0) last[k] = mq[k][0][95:0];
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                int   n;
                ent_t h;
                n = mq[k].size();
                h = (n > 0) ? mq[k][0] : {8'd0, last[k]};
                chk($sformatf("k%0d_ready", k), 104'(ir[k]), 104'(exp_ready(k)));
                chk($sformatf("k%0d_valid", k), 104'(ov[k]), 104'(n > 0));
                chk($sformatf("k%0d_ctrl", k), 104'(octl[k]), 104'(h[103:96]));
                chk($sformatf("k%0d_data", k), 104'(odat[k]), 104'(h[95:0]));
                chk($sformatf("k%0d_count", k), 104'(cnt[k]), 104'(n));
            end
        end
    end

    task automatic nxt;
        @(posedge CLK);
        #1;
    endtask

    task automatic fill_two_k1;
        ordy[1] = 1'b0;
        ivld[1] = 1'b1; ictl[1] = 8'h81; idat[1] = 96'h11;
        nxt;
        idat[1] = 96'h22;
        nxt;
        ivld[1] = 1'b0;
    endtask

    initial begin
        int          nx [2];
        logic [95:0] la [3];
        logic [95:0] pd [2];
        bit          stall [2];
        int          sent, got;
        logic        acc;

        rst_n = 1'b0; flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ivld[k] = 1'b1; ordy[k] = 1'b0; ictl[k] = 8'hFF; idat[k] = 96'h5;
            nx[k] = 1; stall[k] = 1'b0; pd[k] = 96'd0;
        end

        repeat (2) begin
            nxt;
            @(negedge CLK);
            for (int k = 0; k < 2; k++) begin
                chk("reset_valid", 104'(ov[k]), 104'd0);
                chk("reset_ctrl", 104'(octl[k]), 104'd0);
                chk("reset_data", 104'(odat[k]), 104'd0);
                chk("reset_count", 104'(cnt[k]), 104'd0);
            end
        end
        chk_en = 1'b1;
        nxt;
        rst_n = 1'b1;

        // Back-to-back stream 1..100 with the sink always ready.
        for (int k = 0; k < 2; k++) ordy[k] = 1'b1;
        for (int i = 1; i <= 104; i++) begin
            for (int k = 0; k < 2; k++) begin
                ivld[k] = (i <= 100);
                idat[k] = 96'(i);
                ictl[k] = 8'(i);
            end
            @(negedge CLK);
            for (int k = 0; k < 2; k++) begin
                if (ov[k]) begin
                    chk("stream_order", 104'(odat[k]), 104'(nx[k]));
                    nx[k]++;
                end
            end
            nxt;
        end
        for (int k = 0; k < 2; k++) begin
            chk("stream_total", 104'(nx[k]), 104'd101);
            ivld[k] = 1'b0;
        end

        // Skid fill on the SKID=1 stage: A,B held, C stalled, then drained in order.
        la[0] = 96'hA; la[1] = 96'hB; la[2] = 96'hC;
        sent = 0; got = 0;
        ordy[1] = 1'b0; ivld[1] = 1'b1; idat[1] = la[0]; ictl[1] = 8'h3C;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (c == 2 || c == 3) begin
                chk("skid_count", 104'(cnt[1]), 104'd2);
                chk("skid_ready", 104'(ir[1]), 104'd0);
            end
            if (ov[1] && ordy[1]) begin
                if (got < 3) chk("skid_order", 104'(odat[1]), 104'(la[got]));
                got++;
            end
            acc = ivld[1] && ir[1];
            nxt;
            if (acc) begin
                sent++;
                if (sent < 3) idat[1] = la[sent];
                else ivld[1] = 1'b0;
            end
            if (c == 4) ordy[1] = 1'b1;
        end
        chk("skid_emitted", 104'(got), 104'd3);

        // Flush a full stage while an input handshake is offered.
        fill_two_k1;
        @(negedge CLK);
        chk("flush_pre_count", 104'(cnt[1]), 104'd2);
        chk("flush_pre_ctrl", 104'(octl[1]), 104'h81);
        flush = 1'b1; ivld[1] = 1'b1; idat[1] = 96'h33; ictl[1] = 8'h7E;
        nxt;
        flush = 1'b0; ivld[1] = 1'b0;
        @(negedge CLK);
        chk("flush_valid", 104'(ov[1]), 104'd0);
        chk("flush_ctrl", 104'(octl[1]), 104'd0);
        chk("flush_count", 104'(cnt[1]), 104'd0);
        nxt;
        ivld[1] = 1'b1; idat[1] = 96'h44; ictl[1] = 8'h05; ordy[1] = 1'b1;
        nxt;
        ivld[1] = 1'b0;
        @(negedge CLK);
        chk("post_flush_valid", 104'(ov[1]), 104'd1);
        chk("post_flush_data", 104'(odat[1]), 104'h44);
        chk("post_flush_ctrl", 104'(octl[1]), 104'h05);
        nxt;

        // Random traffic with random back-pressure and occasional flush.
        for (int c = 0; c < 1000; c++) begin
            for (int k = 0; k < 2; k++) begin
                ivld[k] = ($urandom_range(0, 9) < 7);
                ordy[k] = 1'($urandom_range(0, 1));
                idat[k] = {$urandom, $urandom, $urandom};
                ictl[k] = 8'($urandom);
            end
            flush = ($urandom_range(0, 49) == 0);
            @(negedge CLK);
            for (int k = 0; k < 2; k++) begin
                if (stall[k]) chk("stall_stable", 104'(odat[k]), 104'(pd[k]));
                stall[k] = ov[k] && !ordy[k] && !flush;
                pd[k] = odat[k];
            end
            nxt;
        end
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ivld[k] = 1'b0; ordy[k] = 1'b1;
        end
        repeat (4) nxt;

        // Reset while full with handshakes active on both sides.
        fill_two_k1;
        rst_n = 1'b0; ivld[1] = 1'b1; ordy[1] = 1'b1; idat[1] = 96'h55;
        nxt;
        rst_n = 1'b1; ivld[1] = 1'b0;
        @(negedge CLK);
        chk("rst_mid_valid", 104'(ov[1]), 104'd0);
        chk("rst_mid_ctrl", 104'(octl[1]), 104'd0);
        chk("rst_mid_data", 104'(odat[1]), 104'd0);
        chk("rst_mid_count", 104'(cnt[1]), 104'd0);
        repeat (5) begin
            nxt;
            @(negedge CLK);
            chk("rst_mid_no_emit", 104'(ov[1]), 104'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
